mtr_drv_pwm: RTL and testbench

//  Consumer of the PID wheel-speed outputs. Converts signed 11-bit lft_spd/rght_spd into complementary,
//  non-overlapping PWM pairs that drive each H-bridge. Each speed is double-buffered and updated only
//  at a PWM period boundary, so a new speed never takes effect in the middle of a period.
//  One instance drives both wheels and shares a single free-running period counter.

---
 rtl/mtr_drv_pwm.sv | 60 ++++++
 tb/tb_mtr_drv_pwm.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: dual-channel complementary PWM H-bridge driver with dead time and period-aligned speed updates
//   clk        system clock
//   rst_n      synchronous active-low reset
//   en         drive enable; low forces all PWM outputs low and restarts dead time
//   lft_spd    signed left wheel speed
//   rght_spd   signed right wheel speed
//   lftPWM1/2  left high-side / low-side drive
//   rghtPWM1/2 right high-side / low-side drive
//   prd_done   high in the cycle where the period counter is at its last count
module mtr_drv_pwm #(
    parameter int PWM_BITS   = 11,
    parameter int NONOVERLAP = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PWM_BITS-1:0] lft_spd,
    input  logic [PWM_BITS-1:0] rght_spd,
    output logic                lftPWM1,
    output logic                lftPWM2,
    output logic                rghtPWM1,
    output logic                rghtPWM2,
    output logic                prd_done
);
    localparam int SW = $clog2(NONOVERLAP + 1);
    localparam logic [SW-1:0] NO = SW'(NONOVERLAP);
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] spd [2];
    assign spd[0]   = lft_spd;
    assign spd[1]   = rght_spd;
    assign prd_done = &cnt;
    always_ff @(posedge clk)
        cnt <= rst_n ? cnt + 1'b1 : '0;
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [PWM_BITS-1:0] duty;
        logic [SW-1:0]       stb;
        logic                raw, raw_nxt, p1, p2;
        assign raw_nxt = cnt < duty;
        always_ff @(posedge clk)
            if (!rst_n) begin
                duty <= {1'b1, {(PWM_BITS-1){1'b0}}};
                raw  <= 1'b0;
                stb  <= '0;
                p1   <= 1'b0;
                p2   <= 1'b0;
            end else begin
                // offset binary: flipping the sign bit maps -1024..1023 onto 0..2047
                if (prd_done) duty <= {~spd[c][PWM_BITS-1], spd[c][PWM_BITS-2:0]};
                raw <= raw_nxt;
                // dead-time counter restarts on every raw edge and is held clear while disabled
                stb <= (!en || raw_nxt != raw) ? '0 : (stb == NO) ? stb : stb + 1'b1;
                p1  <= en & raw & (stb >= NO);
                p2  <= en & ~raw & (stb >= NO);
            end
    end
    assign lftPWM1  = g_ch[0].p1;
    assign lftPWM2  = g_ch[0].p2;
    assign rghtPWM1 = g_ch[1].p1;
    assign rghtPWM2 = g_ch[1].p2;
endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb_mtr_drv_pwm: scoreboard bench for mtr_drv_pwm; per-period high-time counts, overlap, enable guard and prd_done timing
//   Stimulus pushes hand-computed per-period high times tagged with the window they govern;
//   the monitor accumulates each output over a window and pops/compares at window close.
module tb_mtr_drv_pwm;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    logic [10:0] lft_spd = '0, rght_spd = '0;
    logic lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_done;
    typedef struct {int tag; int l1; int l2; int r1; int r2;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int tcnt = 0, ecnt = 0, widx = 0;
    int a1 = 0, a2 = 0, b1 = 0, b2 = 0;

    mtr_drv_pwm dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .lftPWM1(lftPWM1), .lftPWM2(lftPWM2), .rghtPWM1(rghtPWM1), .rghtPWM2(rghtPWM2),
        .prd_done(prd_done)
    );

    always #5 clk = ~clk;

    // reference period position and cycles since enable/reset release
    always @(posedge clk) begin
        tcnt <= !rst_n ? 0 : (tcnt + 1) % 2048;
        ecnt <= (!rst_n || !en) ? 0 : (ecnt < 40 ? ecnt + 1 : ecnt);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int l1, input int l2, input int r1, input int r2);
        exp_t e;
        e.tag = widx + 1; e.l1 = l1; e.l2 = l2; e.r1 = r1; e.r2 = r2;
        q.push_back(e);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (tcnt != v && n < 5000);
        if (tcnt != v) begin
            checks++; errors++;
            $display("FAIL wait_cnt actual=%0d expected=%0d", tcnt, v);
        end
    endtask

    task automatic step(input int at, input int l, input int r,
                        input int l1, input int l2, input int r1, input int r2);
        logic [31:0] lv, rv;
        lv = l; rv = r;
        wait_cnt(at);
        lft_spd = lv[10:0]; rght_spd = rv[10:0];
        if (at != 2047) wait_cnt(2047);
        push(l1, l2, r1, r2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("overlap_l", int'(lftPWM1 & lftPWM2), 0);
        chk("overlap_r", int'(rghtPWM1 & rghtPWM2), 0);
        chk("prd_done", int'(prd_done), int'(tcnt == 2047));
        if (ecnt <= 32) chk("en_guard", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        a1 += int'(lftPWM1); a2 += int'(lftPWM2); b1 += int'(rghtPWM1); b2 += int'(rghtPWM2);
        if (tcnt == 1) begin
            if (q.size() > 0 && q[0].tag == widx) begin
                e = q.pop_front();
                chk($sformatf("lft_pwm1_w%0d", widx), a1, e.l1);
                chk($sformatf("lft_pwm2_w%0d", widx), a2, e.l2);
                chk($sformatf("rght_pwm1_w%0d", widx), b1, e.r1);
                chk($sformatf("rght_pwm2_w%0d", widx), b2, e.r2);
            end
            a1 = 0; a2 = 0; b1 = 0; b2 = 0;
            widx++;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_done}), 0);
        rst_n = 1'b1;
        push(992, 992, 992, 992);
        step(2047,     0,    0,  992,  992,  992,  992);
        step(2047,   512, -512, 1504,  480,  480, 1504);
        step(1000,  -256, -512,  736, 1248,  480, 1504);
        step(2047, -1024, 1023,    0, 2048, 2015,    0);
        step(2047, -1024, 1023,    0, 2048, 2015,    0);
        step(2047,     0,    0,  992,  992,  992,  992);
        step(2047, -1000, -991,    0, 1992,    1, 1983);
        step(2047,   992,  991, 1984,    0, 1983,    1);
        wait_cnt(2047);
        wait_cnt($urandom_range(100, 900));
        en = 1'b0;
        repeat ($urandom_range(1, 300)) @(negedge clk);
        #1;
        en = 1'b1;
        wait_cnt(2047);
        step(2047,     0,    0,  992,  992,  992,  992);
        step(2047,   300,  300, 1292,  692, 1292,  692);
        wait_cnt(2047);
        wait_cnt(700);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_done}), 0);
        rst_n = 1'b1;
        push(992, 992, 992, 992);
        step(2047,   300,  300, 1292,  692, 1292,  692);
        wait_cnt(2047);
        wait_cnt(10);
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
